mult_reduce: RTL and testbench
==============================

MULT_REDUCE -- requirements
Module: mult_reduce

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand width of the upstream multiplier.
REQ-002 SHALL have parameter NrInputs, default 32, number of partial products; power of two, >= 2.
REQ-003 SHALL have parameter TAGW, default 4, width of the sideband tag carried with each product.
REQ-004 SHALL derive localparam STAGES = log2(NrInputs), which is 5 at defaults.
REQ-005 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_i  input  1  reset, asynchronous, active-high.
REQ-007 en_i  input  1  pipeline advance enable; low = stall.
REQ-008 flush_i  input  1  synchronous discard of all in-flight work.
REQ-009 pp_i  input  array [NrInputs] of XLEN*2+1  partial products from the multiplier cell stage.
REQ-010 valid_i  input  1  pp_i/tag_i hold a new operand set; driven by the cell stage's ready_o.
REQ-011 tag_i  input  TAGW  opaque identifier travelling with the operand set.
REQ-012 result_o  output  XLEN*2  reduced product.
REQ-013 valid_o  output  1  result_o/tag_o are valid this cycle.
REQ-014 tag_o  output  TAGW  tag of the operand set now on result_o.
REQ-015 busy_o  output  1  at least one pipeline stage holds a valid entry.

Function
REQ-016 SHALL implement a registered binary adder tree of STAGES levels: level k holds NrInputs/2^k sums; each sum adds pairs 2j and 2j+1 from level k-1, with level 0 = pp_i.
REQ-017 Each level SHALL carry its own valid bit and tag register, forming a STAGES-deep pipeline.
REQ-018 All internal sums SHALL be XLEN*2+1 bits wide, wrapping modulo 2^(XLEN*2+1); overflow is discarded with no flag.
REQ-019 result_o SHALL equal the low XLEN*2 bits of the final level register.
REQ-020 With en_i=1 and no stall, latency SHALL be exactly STAGES cycles from the edge sampling valid_i=1 to valid_o=1.
REQ-021 Throughput SHALL be one operand set per cycle; back-to-back valid_i SHALL yield back-to-back valid_o in the same order.
REQ-022 pp_i, valid_i and tag_i SHALL be sampled only on edges where en_i=1.
REQ-023 On any edge with en_i=0, every data, tag and valid register SHALL hold its value; there is no bubble compression.
REQ-024 While stalled, result_o, tag_o and valid_o SHALL remain stable.
REQ-025 flush_i=1 SHALL clear every valid bit on that edge, regardless of en_i.
REQ-026 flush_i SHALL take priority over en_i, and the input sampled on a flush edge SHALL be discarded.
REQ-027 After a flush edge, valid_o and busy_o SHALL be 0 from the next cycle.
REQ-028 On a flush edge, data and tag registers SHALL be cleared to 0.
REQ-029 busy_o SHALL be the OR of all level valid bits, including the output level.
REQ-030 valid_o SHALL be a direct register output with no combinational path from any input.
REQ-031 Entries with valid=0 SHALL still be computed, but SHALL never raise valid_o.

Reset
REQ-032 rst_i=1 SHALL immediately (asynchronously) clear all data, tag and valid registers to 0, so result_o=0, tag_o=0, valid_o=0 and busy_o=0.
REQ-033 Reset asserted mid-operation SHALL drop all in-flight entries, and none SHALL appear after release.
REQ-034 The first valid_i accepted after reset release SHALL produce valid_o exactly STAGES cycles later.

Verification
REQ-035 Defaults; pp_i[0]=5, pp_i[31]=7, others 0, valid_i=1 for 1 cycle, tag_i=3 -> after 5 cycles valid_o=1 for 1 cycle, result_o=12, tag_o=3.
REQ-036 All 32 pp_i=2^65-1 -> result_o=64'hFFFF_FFFF_FFFF_FFE0 (wrap check).
REQ-037 Three consecutive valid_i with tags 1,2,3 and pp_i[0]=10,20,30 -> valid_o high on 3 consecutive cycles, results 10,20,30 with tags 1,2,3.
REQ-038 en_i=0 for 2 cycles starting 2 cycles after the input edge -> valid_o rises at cycle 7, not 5; result and tag are held unchanged through the stall.
REQ-039 flush_i=1 for 1 cycle with 3 entries in flight -> valid_o never asserts for them, busy_o=0 the next cycle, and a new input afterwards emerges after 5 cycles.
REQ-040 rst_i pulsed asynchronously between edges with entries in flight -> outputs read 0 immediately and no valid_o follows.

Source files
------------

// File: rtl/mult_reduce_if.sv
// Handshake/data bundle between the multiplier cell stage and the reduction tree.
interface mult_reduce_if #(
  parameter int XLEN     = 32,
  parameter int NrInputs = 32,
  parameter int TAGW     = 4
);
  logic                             en_i;
  logic                             flush_i;
  logic [NrInputs-1:0][2*XLEN:0]    pp_i;
  logic                             valid_i;
  logic [TAGW-1:0]                  tag_i;
  logic [2*XLEN-1:0]                result_o;
  logic                             valid_o;
  logic [TAGW-1:0]                  tag_o;
  logic                             busy_o;

  modport master (
    output en_i, flush_i, pp_i, valid_i, tag_i,
    input  result_o, valid_o, tag_o, busy_o
  );

  modport slave (
    input  en_i, flush_i, pp_i, valid_i, tag_i,
    output result_o, valid_o, tag_o, busy_o
  );
endinterface

// File: rtl/mult_reduce.sv
// Pipelined binary adder tree reducing NrInputs partial products into one product,
// one level per stage, with per-level valid/tag sideband and stall/flush control.
module mult_reduce_node #(
  parameter int W = 65
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         flush_i,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  // Sum wraps at W bits; overflow is intentionally dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        sum <= '0;
    else if (flush_i) sum <= '0;
    else if (en_i)    sum <= a + b;
  end
endmodule

module mult_reduce #(
  parameter int XLEN     = 32,
  parameter int NrInputs = 32,
  parameter int TAGW     = 4
) (
  input logic        clk_i,
  input logic        rst_i,
  mult_reduce_if.slave bus
);
  localparam int STAGES = $clog2(NrInputs);
  localparam int W      = 2*XLEN + 1;
  localparam int Root   = 2*NrInputs - 2;

  // Flattened tree: level k occupies [2N - 2N/2^k, 2N - 2N/2^(k+1)); leaves are pp_i.
  logic [W-1:0]               tree [2*NrInputs-1];
  logic [STAGES:1]            vld_pipe;
  logic [STAGES:1][TAGW-1:0]  tag_pipe;
  logic                       unused_msb;

  for (genvar j = 0; j < NrInputs; j++) begin : g_leaf
    assign tree[j] = bus.pp_i[j];
  end

  for (genvar k = 1; k <= STAGES; k++) begin : g_lvl
    localparam int Src = 2*NrInputs - ((2*NrInputs) >> (k-1));
    localparam int Dst = 2*NrInputs - ((2*NrInputs) >> k);
    for (genvar j = 0; j < (NrInputs >> k); j++) begin : g_node
      mult_reduce_node #(.W(W)) u_node (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (bus.en_i),
        .flush_i (bus.flush_i),
        .a       (tree[Src + 2*j]),
        .b       (tree[Src + 2*j + 1]),
        .sum     (tree[Dst + j])
      );
    end
  end

  // Flush wins over enable; a stall freezes every stage, no bubble squeezing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else if (bus.flush_i) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else if (bus.en_i) begin
      vld_pipe[1] <= bus.valid_i;
      tag_pipe[1] <= bus.tag_i;
      for (int k = 2; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  assign bus.result_o = tree[Root][2*XLEN-1:0];
  assign unused_msb   = tree[Root][W-1];
  assign bus.valid_o  = vld_pipe[STAGES];
  assign bus.tag_o    = tag_pipe[STAGES];
  assign bus.busy_o   = |vld_pipe;
endmodule

// File: tb/tb_mult_reduce.sv
// Directed bench for mult_reduce at default parameters: latency, wrap, streaming,
// stall, flush and asynchronous reset behaviour.
module tb_mult_reduce;
  localparam int XLEN = 32;
  localparam int NI   = 32;
  localparam int TAGW = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   seen;

  mult_reduce_if #(.XLEN(XLEN), .NrInputs(NI), .TAGW(TAGW)) bus ();

  mult_reduce #(.XLEN(XLEN), .NrInputs(NI), .TAGW(TAGW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2*XLEN:0] p0, input logic [TAGW-1:0] t);
    bus.valid_i = v;
    bus.pp_i    = '0;
    bus.pp_i[0] = p0;
    bus.tag_i   = t;
  endtask

  // Entered in cycle 'start' (input presented in cycle 0); bounded search for valid_o.
  task automatic wait_out(input string tag, input int start, input int exp_lat,
                          input logic [63:0] exp_res, input logic [TAGW-1:0] exp_tag);
    int lat;
    lat = -1;
    for (int c = start; c <= start + 20; c++) begin
      if (bus.valid_o) begin
        lat = c;
        break;
      end
      cyc();
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, bus.result_o, exp_res);
    chk({tag, "_tag"}, 64'(bus.tag_o), 64'(exp_tag));
  endtask

  initial begin
    bus.en_i    = 1'b1;
    bus.flush_i = 1'b0;
    drive(1'b0, '0, '0);
    cyc();
    cyc();
    chk("rst_res",   bus.result_o, 64'd0);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_tag",   64'(bus.tag_o), 64'd0);
    chk("rst_busy",  64'(bus.busy_o), 64'd0);
    rst_i = 1'b0;

    // Two sparse operands, first accept after reset release
    drive(1'b1, 65'd5, 4'd3);
    bus.pp_i[31] = 65'd7;
    cyc();
    drive(1'b0, '0, '0);
    chk("basic_busy", 64'(bus.busy_o), 64'd1);
    wait_out("basic", 1, 5, 64'd12, 4'd3);
    cyc();
    chk("basic_pulse", 64'(bus.valid_o), 64'd0);

    // All-ones operands wrap modulo 2^65
    drive(1'b1, '0, 4'd2);
    for (int i = 0; i < NI; i++) bus.pp_i[i] = {(2*XLEN+1){1'b1}};
    cyc();
    drive(1'b0, '0, '0);
    wait_out("wrap", 1, 5, 64'hFFFF_FFFF_FFFF_FFE0, 4'd2);
    cyc();
    chk("wrap_idle", 64'(bus.busy_o), 64'd0);

    // Back-to-back operand sets
    drive(1'b1, 65'd10, 4'd1); cyc();
    drive(1'b1, 65'd20, 4'd2); cyc();
    drive(1'b1, 65'd30, 4'd3); cyc();
    drive(1'b0, '0, '0);
    cyc();
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("b2b_valid", 64'(bus.valid_o), 64'd1);
      chk("b2b_res",   bus.result_o, 64'(10*(i+1)));
      chk("b2b_tag",   64'(bus.tag_o), 64'(i+1));
      cyc();
    end
    chk("b2b_end", 64'(bus.valid_o), 64'd0);

    // Two-cycle stall two cycles after input, then stall while output is valid
    drive(1'b1, 65'd9, 4'd5);
    cyc();
    drive(1'b0, '0, '0);
    cyc();
    bus.en_i = 1'b0;
    cyc();
    cyc();
    chk("stall_busy", 64'(bus.busy_o), 64'd1);
    bus.en_i = 1'b1;
    wait_out("stall", 4, 7, 64'd9, 4'd5);
    bus.en_i = 1'b0;
    cyc();
    chk("hold_valid", 64'(bus.valid_o), 64'd1);
    chk("hold_res",   bus.result_o, 64'd9);
    chk("hold_tag",   64'(bus.tag_o), 64'd5);
    bus.en_i = 1'b1;
    cyc();
    chk("hold_release", 64'(bus.valid_o), 64'd0);

    // Flush with three entries in flight; input on the flush edge is dropped
    drive(1'b1, 65'd1, 4'd6); cyc();
    drive(1'b1, 65'd2, 4'd7); cyc();
    drive(1'b1, 65'd3, 4'd8); cyc();
    drive(1'b1, 65'd55, 4'd10);
    bus.flush_i = 1'b1;
    cyc();
    bus.flush_i = 1'b0;
    drive(1'b0, '0, '0);
    chk("flush_busy",  64'(bus.busy_o), 64'd0);
    chk("flush_valid", 64'(bus.valid_o), 64'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.valid_o) seen++;
      cyc();
    end
    chk("flush_ghost", 64'(seen), 64'd0);
    drive(1'b1, 65'd42, 4'd9);
    cyc();
    drive(1'b0, '0, '0);
    wait_out("postflush", 1, 5, 64'd42, 4'd9);
    cyc();

    // Asynchronous reset between edges while an entry sits on the output
    drive(1'b1, 65'd77, 4'd4); cyc();
    drive(1'b1, 65'd88, 4'd11); cyc();
    drive(1'b0, '0, '0);
    wait_out("prerst", 2, 5, 64'd77, 4'd4);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.valid_o), 64'd0);
    chk("arst_res",   bus.result_o, 64'd0);
    chk("arst_tag",   64'(bus.tag_o), 64'd0);
    chk("arst_busy",  64'(bus.busy_o), 64'd0);
    cyc();
    cyc();
    rst_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.valid_o) seen++;
      cyc();
    end
    chk("arst_ghost", 64'(seen), 64'd0);
    drive(1'b1, 65'd3, 4'd12);
    cyc();
    drive(1'b0, '0, '0);
    wait_out("postrst", 1, 5, 64'd3, 4'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
